// File: rtl/fp_op_scheduler_pkg.sv
// Shared definitions for the FP op scheduler: op-select codes, FSM states, command layout.
// FPQ_SEQ_TAG_EN adds a sequence tag field to the command record.
package fpq_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 3;
    localparam int DEF_TAG_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Default-width command record; the top re-declares it against its own parameters.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] op1;
        logic [DEF_DATA_W-1:0] op2;
        logic [DEF_SEL_W-1:0]  sel;
`ifdef FPQ_SEQ_TAG_EN
        logic [DEF_TAG_W-1:0]  tag;
`endif
    } cmd_t;

endpackage

// File: rtl/fp_op_scheduler_fifo.sv
// fpq_fifo: generic synchronous FIFO with first-word-fall-through head, power-of-2 depth.
// Push while full and pop while empty are ignored.
module fpq_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// fp_op_scheduler: queues CPU FP commands, issues them one at a time, returns results in order.
// Define FPQ_SEQ_TAG_EN to carry a per-push sequence tag through to result_tag.
module fp_op_scheduler
    import fpq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 3,
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 8,
    parameter int TAG_W     = 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [DATA_W-1:0]              op1,
    input  logic [DATA_W-1:0]              op2,
    input  logic [SEL_W-1:0]               op_sel,
    input  logic                           op_strobe,
    input  logic                           cpu_pop,
    input  logic                           err_clr,
    output logic [DATA_W-1:0]              result,
`ifdef FPQ_SEQ_TAG_EN
    output logic [TAG_W-1:0]               result_tag,
`endif
    output logic                           cmd_full,
    output logic                           res_empty,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
    output logic [$clog2(RES_DEPTH+1)-1:0] res_count,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           exe_start,
    output logic [DATA_W-1:0]              exe_op1,
    output logic [DATA_W-1:0]              exe_op2,
    output logic [SEL_W-1:0]               exe_sel,
    input  logic                           exe_done,
    input  logic [DATA_W-1:0]              exe_result
);

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [SEL_W-1:0]  sel;
`ifdef FPQ_SEQ_TAG_EN
        logic [TAG_W-1:0]  tag;
`endif
    } cmd_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
`ifdef FPQ_SEQ_TAG_EN
        logic [TAG_W-1:0]  tag;
`endif
    } res_entry_t;

    state_t     state;
    state_t     state_n;
    cmd_entry_t cmd_in;
    cmd_entry_t cmd_head;
    res_entry_t res_in;
    res_entry_t res_head;
    logic       cmd_empty;
    logic       cmd_pop;
    logic       res_full;
    logic       res_push;

`ifdef FPQ_SEQ_TAG_EN
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] exe_tag;
`endif

    always_comb begin
        cmd_in.op1  = op1;
        cmd_in.op2  = op2;
        cmd_in.sel  = op_sel;
        res_in.data = exe_result;
`ifdef FPQ_SEQ_TAG_EN
        cmd_in.tag  = tag_cnt;
        res_in.tag  = exe_tag;
`endif
    end

    fpq_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_entry_t)) u_cmd_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (op_strobe),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    fpq_fifo #(.DEPTH(RES_DEPTH), .T(res_entry_t)) u_res_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (res_push),
        .wdata (res_in),
        .pop   (cpu_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    // Issue only with a free result slot, so the WAIT-state write can never be dropped.
    always_comb begin
        state_n   = state;
        cmd_pop   = 1'b0;
        res_push  = 1'b0;
        exe_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cmd_empty && !res_full) begin
                    cmd_pop = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                exe_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (exe_done) begin
                    res_push = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exe_op1   <= '0;
            exe_op2   <= '0;
            exe_sel   <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (cmd_pop) begin
                exe_op1 <= cmd_head.op1;
                exe_op2 <= cmd_head.op2;
                exe_sel <= cmd_head.sel;
            end
            if (cpu_pop && !res_empty) begin
                result <= res_head.data;
            end
            // A new error event outranks a same-cycle clear.
            overflow  <= (op_strobe && cmd_full) || (overflow && !err_clr);
            underflow <= (cpu_pop && res_empty) || (underflow && !err_clr);
        end
    end

`ifdef FPQ_SEQ_TAG_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_cnt    <= '0;
            exe_tag    <= '0;
            result_tag <= '0;
        end else begin
            if (op_strobe && !cmd_full) tag_cnt <= tag_cnt + TAG_W'(1);
            if (cmd_pop)                exe_tag <= cmd_head.tag;
            if (cpu_pop && !res_empty)  result_tag <= res_head.tag;
        end
    end
`endif

endmodule
